// File: rtl/saph_fpu_arbiter.sv
// rtl/saph_fpu_arbiter.sv - round-robin FPU issue arbiter with latency-tracking tag pipe
// Define SAPH_FPU_ARB_CHECK_EN to build the sticky latency-mismatch flag on err.
module saph_fpu_arbiter #(
    parameter int NREQ    = 2,
    parameter int LATENCY = 2,
    parameter int OP_W    = 2,
    parameter int FLT_W   = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NREQ-1:0]                 req_valid,
    output logic [NREQ-1:0]                 req_ready,
    input  logic [NREQ-1:0][OP_W-1:0]       req_op,
    input  logic [NREQ-1:0][FLT_W-1:0]      req_a,
    input  logic [NREQ-1:0][FLT_W-1:0]      req_b,
    output logic                            fpu_valid,
    output logic [OP_W-1:0]                 fpu_op,
    output logic [FLT_W-1:0]                fpu_a,
    output logic [FLT_W-1:0]                fpu_b,
    input  logic                            fpu_res_valid,
    input  logic [FLT_W-1:0]                fpu_res,
    output logic [NREQ-1:0]                 resp_valid,
    output logic [FLT_W-1:0]                resp_data,
    output logic                            err
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic [IDX_W-1:0]   issue_idx;
    logic [LATENCY-1:0] tag_v;
    logic [IDX_W-1:0]   tag_idx [LATENCY];
    logic               head_v;
    logic [IDX_W-1:0]   head_idx;

    // Scan upward from rr_ptr; the first valid requester wins.
    always_comb begin
        int j;
        j         = 0;
        req_ready = '0;
        gnt_idx   = '0;
        gnt_any   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(rr_ptr) + i) % NREQ;
            if (!gnt_any && req_valid[j]) begin
                gnt_any      = 1'b1;
                gnt_idx      = IDX_W'(j);
                req_ready[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            fpu_valid <= 1'b0;
            fpu_op    <= '0;
            fpu_a     <= '0;
            fpu_b     <= '0;
            issue_idx <= '0;
        end else begin
            fpu_valid <= gnt_any;
            if (gnt_any) begin
                rr_ptr    <= (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                issue_idx <= gnt_idx;
                fpu_op    <= req_op[gnt_idx];
                fpu_a     <= req_a[gnt_idx];
                fpu_b     <= req_b[gnt_idx];
            end
        end
    end

    // Only the valid bits need clearing; stale indices are never used.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v <= '0;
        end else begin
            tag_v[0] <= fpu_valid;
            for (int k = 1; k < LATENCY; k++) begin
                tag_v[k] <= tag_v[k-1];
            end
        end
        tag_idx[0] <= issue_idx;
        for (int k = 1; k < LATENCY; k++) begin
            tag_idx[k] <= tag_idx[k-1];
        end
    end

    assign head_v   = tag_v[LATENCY-1];
    assign head_idx = tag_idx[LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                resp_valid[i] <= head_v && (head_idx == IDX_W'(i));
            end
            if (head_v) begin
                resp_data <= fpu_res;
            end
        end
    end

`ifdef SAPH_FPU_ARB_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (fpu_res_valid != head_v) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_res_valid;
    assign unused_res_valid = fpu_res_valid;
    assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_saph_fpu_arbiter.sv
// tb/tb_saph_fpu_arbiter.sv - randomized self-checking bench for saph_fpu_arbiter
module tb_saph_fpu_arbiter;
    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int OP_W = 2;
    localparam int FW   = 32;
    localparam int H    = 64;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ-1:0][OP_W-1:0] req_op;
    logic [NREQ-1:0][FW-1:0]  req_a;
    logic [NREQ-1:0][FW-1:0]  req_b;
    logic                     fpu_valid;
    logic [OP_W-1:0]          fpu_op;
    logic [FW-1:0]            fpu_a;
    logic [FW-1:0]            fpu_b;
    logic                     fpu_res_valid;
    logic [FW-1:0]            fpu_res;
    logic [NREQ-1:0]          resp_valid;
    logic [FW-1:0]            resp_data;
    logic                     err;
    logic                     spur;

    always #5 clk = ~clk;

    saph_fpu_arbiter #(.NREQ(NREQ), .LATENCY(LAT), .OP_W(OP_W), .FLT_W(FW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .fpu_valid(fpu_valid), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_res_valid(fpu_res_valid), .fpu_res(fpu_res),
        .resp_valid(resp_valid), .resp_data(resp_data), .err(err)
    );

    function automatic logic [FW-1:0] fpu_fn(input logic [OP_W-1:0] op,
                                             input logic [FW-1:0] a, input logic [FW-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    // Fixed-latency FPU lane; not reset, so in-flight results survive an arbiter reset.
    logic [LAT-1:0] fm_v = '0;
    logic [FW-1:0]  fm_d [LAT];
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) begin
            fm_v[k] <= fm_v[k-1];
            fm_d[k] <= fm_d[k-1];
        end
        fm_v[0] <= fpu_valid;
        fm_d[0] <= fpu_fn(fpu_op, fpu_a, fpu_b);
    end
    assign fpu_res_valid = fm_v[LAT-1] | spur;
    assign fpu_res       = fm_d[LAT-1];

    int              errors = 0;
    int              checks = 0;
    int              cyc    = 0;
    int              ptr_m  = 0;
    bit              pend  [NREQ];
    logic [OP_W-1:0] p_op  [NREQ];
    logic [FW-1:0]   p_a   [NREQ];
    logic [FW-1:0]   p_b   [NREQ];
    bit              e_iss_v  [H];
    logic [OP_W-1:0] e_iss_op [H];
    logic [FW-1:0]   e_iss_a  [H];
    logic [FW-1:0]   e_iss_b  [H];
    logic [NREQ-1:0] e_rv     [H];
    logic [FW-1:0]   e_rd     [H];
    logic [OP_W-1:0] last_op;
    logic [FW-1:0]   last_a, last_b, last_rd;
    bit              e_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < H; i++) begin
            e_iss_v[i] = 1'b0;
            e_rv[i]    = '0;
        end
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        ptr_m   = 0;
        last_op = '0;
        last_a  = '0;
        last_b  = '0;
        last_rd = '0;
        e_err   = 1'b0;
    endtask

    // One cycle: new requests, check registered outputs and the grant, then advance the model.
    task automatic step(input logic [NREQ-1:0] allow, input int prob, input bit do_rst, input bit do_spur);
        int s;
        int g;
        int idx;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && allow[i] && ($urandom_range(99) < prob)) begin
                pend[i] = 1'b1;
                p_op[i] = OP_W'($urandom);
                p_a[i]  = $urandom;
                p_b[i]  = $urandom;
            end
        end
        rst  = do_rst;
        spur = do_spur;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = pend[i] && !do_rst;
            req_op[i]    = p_op[i];
            req_a[i]     = p_a[i];
            req_b[i]     = p_b[i];
        end
        #1;
        s = cyc % H;
        if (e_iss_v[s]) begin
            last_op = e_iss_op[s];
            last_a  = e_iss_a[s];
            last_b  = e_iss_b[s];
        end
        if (e_rv[s] != '0) last_rd = e_rd[s];
        check_eq("fpu_valid", 64'(fpu_valid), 64'(e_iss_v[s]));
        check_eq("fpu_op", 64'(fpu_op), 64'(last_op));
        check_eq("fpu_a", 64'(fpu_a), 64'(last_a));
        check_eq("fpu_b", 64'(fpu_b), 64'(last_b));
        check_eq("resp_valid", 64'(resp_valid), 64'(e_rv[s]));
        check_eq("resp_data", 64'(resp_data), 64'(last_rd));
        check_eq("err", 64'(err), 64'(e_err));

        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (ptr_m + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));

        e_iss_v[s] = 1'b0;
        e_rv[s]    = '0;
`ifdef SAPH_FPU_ARB_CHECK_EN
        if (fpu_res_valid != (e_rv[(cyc + 1) % H] != '0)) e_err = 1'b1;
`endif
        if (do_rst) begin
            clear_model();
        end else if (g >= 0) begin
            e_iss_v[(cyc + 1) % H]        = 1'b1;
            e_iss_op[(cyc + 1) % H]       = p_op[g];
            e_iss_a[(cyc + 1) % H]        = p_a[g];
            e_iss_b[(cyc + 1) % H]        = p_b[g];
            e_rv[(cyc + LAT + 2) % H][g]  = 1'b1;
            e_rd[(cyc + LAT + 2) % H]     = fpu_fn(p_op[g], p_a[g], p_b[g]);
            ptr_m   = (g + 1) % NREQ;
            pend[g] = 1'b0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        spur      = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        clear_model();
        for (int i = 0; i < NREQ; i++) begin
            p_op[i] = '0;
            p_a[i]  = '0;
            p_b[i]  = '0;
        end
        repeat (4) @(posedge clk);

        // Single request from requester 0
        idle(5);
        step(4'b0001, 100, 1'b0, 1'b0);
        idle(LAT + 3);

        // Contention between requesters 0 and 1 from reset
        step('0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(4'b0011, 100, 1'b0, 1'b0);
        idle(LAT + 3);

        // Pointer skip: rr_ptr=1, only requester 3 valid, then 0 and 1 compete
        step('0, 0, 1'b1, 1'b0);
        step(4'b0001, 100, 1'b0, 1'b0);
        step(4'b1000, 100, 1'b0, 1'b0);
        step(4'b0011, 100, 1'b0, 1'b0);
        idle(LAT + 4);

        // Reset one cycle before the first of two in-flight results
        step(4'b0110, 100, 1'b0, 1'b0);
        step('0, 0, 1'b0, 1'b0);
        step('0, 0, 1'b1, 1'b0);
        idle(LAT + 3);
        step(4'b1111, 100, 1'b0, 1'b0);
        idle(LAT + 3);

        // Spurious FPU result with an empty tag pipe
        step('0, 0, 1'b0, 1'b1);
        idle(LAT + 3);

        // Back-to-back single requester
        step('0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(4'b0010, 100, 1'b0, 1'b0);
        idle(LAT + 3);

        // Randomized traffic with occasional resets and spurious results
        for (int i = 0; i < 400; i++) begin
            step(NREQ'($urandom), int'($urandom_range(100)),
                 $urandom_range(59) == 0, $urandom_range(39) == 0);
        end
        idle(LAT + 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/saph_fpu_arbiter.md
# saph_fpu_arbiter

Round-robin arbiter that shares one FPU issue port between `NREQ` requesters, such as several `saph_float_incrementer`-style sequencers. It accepts at most one operation per cycle and forwards it to the FPU through a registered issue stage. A tag pipeline tracks the FPU's fixed latency so each result returns only to the requester that issued it. It sits between the requesting blocks and a single `saph_fpu` lane.

## Interface
- `NREQ`, 2: number of requesters (≥1).
- `LATENCY`, 2: FPU issue-to-result latency in cycles (≥1).
- `OP_W`, 2: width of the opaque FPU opcode, which is passed through unchanged.

- `clk`  in  1  GPU clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request strobe.
- `req_ready`  out  NREQ  one-hot grant; a transfer happens when valid&ready.
- `req_op`  in  NREQ×OP_W  per-requester opcode.
- `req_a`, `req_b`  in  float[NREQ]  per-requester operands.
- `fpu_valid`  out  1  issue strobe to the FPU.
- `fpu_op`  out  OP_W  issued opcode.
- `fpu_a`, `fpu_b`  out  float  issued operands.
- `fpu_res_valid`  in  1  FPU result strobe.
- `fpu_res`  in  float  FPU result.
- `resp_valid`  out  NREQ  one-hot result strobe to the owning requester.
- `resp_data`  out  float  result, broadcast to all requesters and qualified by `resp_valid`.
- `err`  out  1  sticky latency-mismatch flag (see Configuration).

## Operation
- **Arbitration (combinational)**
  - The grant goes to the first requester with `req_valid` set, scanning from `rr_ptr` upward modulo NREQ.
  - `req_ready` is one-hot on the granted requester, or all-zero when nothing is valid.
  - `req_ready` depends on `req_valid` (no registered ready). Requesters must hold `req_valid` and their operands stable until accepted.
- **Pointer**
  - On a transfer to requester g, `rr_ptr <= (g+1) mod NREQ`.
  - With no transfer, `rr_ptr` holds.
- **Issue stage**
  - On a transfer, the next cycle has `fpu_valid=1`, with `fpu_op/a/b` = the granted requester's values.
  - Otherwise `fpu_valid=0`, and the data outputs hold their last value.
- **Tag pipe**
  - LATENCY-deep shift register of {valid, index}, where index is ⌈log2 NREQ⌉ bits wide (min 1).
  - The entry is loaded from the issue stage and advances every cycle.
  - The head entry is aligned with `fpu_res_valid`.
- **Response stage (registered)**
  - When the head entry is valid, `resp_valid[index] <= 1` and `resp_data <= fpu_res`.
  - Otherwise `resp_valid <= 0`, and `resp_data` holds.
  - There is no response backpressure: requesters must accept results in the cycle presented.
- **Reset values**
  - Issue stage: `rr_ptr=0`, `fpu_valid=0`, `fpu_op=0`, `fpu_a=fpu_b=0`.
  - Tag pipe: all entries invalid.
  - Outputs: `resp_valid=0`, `resp_data=0`, `err=0`.

## Timing
- A request accepted at the edge ending cycle t issues at t+1, produces its FPU result at t+1+LATENCY, and asserts `resp_valid` at t+2+LATENCY.
- Total latency is LATENCY+2.
- Throughput is one operation per cycle total. With every requester held valid, each requester gets 1/NREQ of the slots, in strict rotation.
- **Single requester:** a requester with continuous `req_valid` and no contention is granted every cycle.
- **Reset mid-operation:** the tag pipe is cleared. Results that arrive in the following LATENCY cycles are discarded (`resp_valid` stays 0), and `rr_ptr` returns to 0.
- **Simultaneous events:** a grant and a response to the same requester in the same cycle are independent and both occur.
- `fpu_res_valid` asserted with the head entry invalid is ignored for routing.

## Configuration
- **`SAPH_FPU_ARB_CHECK_EN` defined**
  - `err` is set the cycle after `fpu_res_valid` differs from the head entry's valid bit.
  - It stays set until `rst`.
- **`SAPH_FPU_ARB_CHECK_EN` not defined**
  - `err` is tied to 0.
  - No comparison logic is built; routing behaviour is identical.

## Test plan
- **Single request:** NREQ=2, LATENCY=2. Requester 0 sends {add, `fconst(1.010)`, `fconst(0.125)`} at cycle 5.
  - `req_ready=2'b01` at cycle 5 and `fpu_valid=1` at cycle 6.
  - FPU model returns `fconst(1.135)` at cycle 8.
  - `resp_valid=2'b01`, `resp_data=fconst(1.135)` at cycle 9.
  - `resp_valid[1]` stays 0 throughout.
- **Contention:** both requesters are held valid for 6 cycles from reset.
  - Grants run 0,1,0,1,0,1.
  - Responses arrive in the same order, each LATENCY+2 cycles after its grant, with requester 1's results carrying its own operand sums (`fconst(3.141)`+`fconst(0.001)`).
- **Pointer skip:** NREQ=4, `rr_ptr=1`, only requester 3 valid.
  - Requester 3 is granted.
  - `rr_ptr` becomes 0 next cycle.
- **Reset mid-flight:** issue 2 operations, then pulse `rst` one cycle before the first result.
  - No `resp_valid` for the next LATENCY+2 cycles.
  - All outputs return to reset values.
  - `rr_ptr=0`.
- **Check macro on:** the FPU model asserts a spurious `fpu_res_valid` with an empty pipe.
  - `err=1` the next cycle and it stays high.
  - With the macro off, `err` stays 0.
- **Back-to-back single requester:** requester 1 is valid for 10 consecutive cycles.
  - 10 grants in a row.
  - 10 consecutive `resp_valid[1]` pulses starting 4 cycles after the first grant.
